// File: rtl/tb_check_pkg.sv
// rtl/tb_check_pkg.sv - shared state encoding and default widths for the mismatch scoreboard
package tb_check_pkg;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_RUN  = 2'd1,
        SB_DONE = 2'd2
    } sb_state_e;

    localparam int DEF_DATA_W         = 1;
    localparam int DEF_CNT_W          = 32;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // clr has priority so a run restart never keeps a stale increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mismatch_scoreboard.sv
// rtl/mismatch_scoreboard.sv - ref/dut compare scoreboard with counters and first-mismatch capture
// Optional RUN cycle limit: MISMATCH_SCOREBOARD_TIMEOUT_EN
module mismatch_scoreboard
    import tb_check_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] ref_out,
    input  logic [DATA_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  error_count,
    output logic              first_err_valid,
    output logic [CNT_W-1:0]  first_err_cycle,
    output logic [DATA_W-1:0] first_err_bits
);

    sb_state_e         state_q, state_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic [CNT_W-1:0]  first_err_cycle_q, first_err_cycle_d;
    logic [DATA_W-1:0] first_err_bits_q, first_err_bits_d;
    logic              timeout_q, timeout_d;

    logic              run;
    logic              start_ok;
    logic              sample_hit;
    logic              err_hit;
    logic              limit_hit;
    logic [DATA_W-1:0] diff;
    logic [CNT_W-1:0]  cycle_idx;

    assign run        = (state_q == SB_RUN);
    assign start_ok   = start && !run;
    assign diff       = ref_out ^ dut_out;
    assign sample_hit = run && sample_valid;
    assign err_hit    = sample_hit && (|diff);

`ifdef MISMATCH_SCOREBOARD_TIMEOUT_EN
    assign limit_hit = run && !stop && (cycle_idx == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign limit_hit          = 1'b0;
`endif

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk(clk), .reset(reset), .clr(start_ok), .inc(run), .cnt(cycle_idx)
    );
    sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
        .clk(clk), .reset(reset), .clr(start_ok), .inc(sample_hit), .cnt(sample_count)
    );
    sat_counter #(.WIDTH(CNT_W)) u_error_cnt (
        .clk(clk), .reset(reset), .clr(start_ok), .inc(err_hit), .cnt(error_count)
    );

    always_comb begin
        state_d           = state_q;
        first_err_valid_d = first_err_valid_q;
        first_err_cycle_d = first_err_cycle_q;
        first_err_bits_d  = first_err_bits_q;
        timeout_d         = timeout_q;
        case (state_q)
            SB_RUN: begin
                if (err_hit && !first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_cycle_d = cycle_idx;
                    first_err_bits_d  = diff;
                end
                // an explicit stop on the limit cycle is a normal end, not a timeout
                if (stop) begin
                    state_d = SB_DONE;
                end else if (limit_hit) begin
                    state_d   = SB_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                if (start_ok) begin
                    state_d           = SB_RUN;
                    first_err_valid_d = 1'b0;
                    first_err_cycle_d = '0;
                    first_err_bits_d  = '0;
                    timeout_d         = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= SB_IDLE;
            first_err_valid_q <= 1'b0;
            first_err_cycle_q <= '0;
            first_err_bits_q  <= '0;
            timeout_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_cycle_q <= first_err_cycle_d;
            first_err_bits_q  <= first_err_bits_d;
            timeout_q         <= timeout_d;
        end
    end

    assign busy            = run;
    assign done            = (state_q == SB_DONE);
    assign timeout         = timeout_q;
    assign pass            = done && (error_count == '0) && (sample_count != '0) && !timeout_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_cycle = first_err_cycle_q;
    assign first_err_bits  = first_err_bits_q;

endmodule

// File: tb/tb_mismatch_scoreboard.sv
// tb/tb_mismatch_scoreboard.sv - directed and random stimulus against a run-level reference model
module tb_mismatch_scoreboard;

    localparam int DW   = 4;
    localparam int CW   = 4;
    localparam int TO   = 10;
    localparam int MAXC = (1 << CW) - 1;
`ifdef MISMATCH_SCOREBOARD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] ref_out = '0;
    logic [DW-1:0] dut_out = '0;
    logic          busy, done, pass, timeout, first_err_valid;
    logic [CW-1:0] sample_count, error_count, first_err_cycle;
    logic [DW-1:0] first_err_bits;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: run flags plus unbounded tallies, saturated only when compared
    bit m_run, m_done, m_to, m_fv;
    int m_samples, m_errs, m_cyc, m_fcyc, m_fbits;

    always #5 clk = ~clk;

    mismatch_scoreboard #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_valid(sample_valid), .ref_out(ref_out), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .sample_count(sample_count), .error_count(error_count),
        .first_err_valid(first_err_valid), .first_err_cycle(first_err_cycle),
        .first_err_bits(first_err_bits)
    );

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_run = 0; m_done = 0; m_to = 0; m_fv = 0;
        m_samples = 0; m_errs = 0; m_cyc = 0; m_fcyc = 0; m_fbits = 0;
    endtask

    task automatic model_step();
        if (m_run) begin
            if (sample_valid) begin
                m_samples++;
                if (ref_out != dut_out) begin
                    m_errs++;
                    if (!m_fv) begin
                        m_fv = 1; m_fcyc = sat(m_cyc); m_fbits = int'(ref_out ^ dut_out);
                    end
                end
            end
            if (stop) begin
                m_run = 0; m_done = 1;
            end else if (TO_EN && m_cyc == TO - 1) begin
                m_run = 0; m_done = 1; m_to = 1;
            end
            m_cyc++;
        end else if (start) begin
            model_clear();
            m_run = 1;
        end
    endtask

    task automatic check_all(input string p);
        bit exp_pass;
        exp_pass = m_done && m_errs == 0 && m_samples != 0 && !m_to;
        check({p, ".busy"}, 32'(busy), 32'(m_run));
        check({p, ".done"}, 32'(done), 32'(m_done));
        check({p, ".pass"}, 32'(pass), 32'(exp_pass));
        check({p, ".timeout"}, 32'(timeout), 32'(m_to));
        check({p, ".samples"}, 32'(sample_count), 32'(sat(m_samples)));
        check({p, ".errors"}, 32'(error_count), 32'(sat(m_errs)));
        check({p, ".fe_valid"}, 32'(first_err_valid), 32'(m_fv));
        check({p, ".fe_cycle"}, 32'(first_err_cycle), 32'(m_fcyc));
        check({p, ".fe_bits"}, 32'(first_err_bits), 32'(m_fbits));
    endtask

    task automatic step(input string p);
        model_step();
        @(posedge clk);
        #1;
        check_all(p);
    endtask

    task automatic drive(input bit s, input bit sp, input bit v, input logic [DW-1:0] r,
                         input logic [DW-1:0] d);
        start = s; stop = sp; sample_valid = v; ref_out = r; dut_out = d;
    endtask

    task automatic do_reset(input string p);
        #2 reset = 1'b1;
        model_clear();
        #1 check_all({p, ".async"});
        @(posedge clk);
        #1 reset = 1'b0;
        check_all({p, ".held"});
    endtask

    initial begin
        model_clear();
        #2 check_all("reset");
        #10 reset = 1'b0;

        // 1: eight matching samples then stop
        drive(1, 0, 0, 0, 0); step("t1_start");
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, DW'(i), DW'(i)); step("t1_run");
        end
        drive(0, 1, 0, 0, 0); step("t1_stop");
        check("t1_count", 32'(sample_count), 32'd8);
        check("t1_pass", 32'(pass), 32'd1);

        // 2: mismatches at RUN cycles 3 and 5
        drive(1, 0, 0, 0, 0); step("t2_start");
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 1, (i == 3 || i == 5) ? 0 : 1); step("t2_run");
        end
        drive(0, 1, 0, 0, 0); step("t2_stop");
        check("t2_errors", 32'(error_count), 32'd2);
        check("t2_fe_cycle", 32'(first_err_cycle), 32'd3);
        check("t2_fe_bits", 32'(first_err_bits), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);

        // 3: 20 mismatching samples saturate a 4-bit counter
        drive(1, 0, 0, 0, 0); step("t3_start");
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 4'hA, 4'h5); step("t3_run");
        end
        drive(0, 1, 0, 0, 0); step("t3_stop");
        check("t3_errors", 32'(error_count), 32'(sat(TO_EN ? TO : 20)));
        check("t3_samples", 32'(sample_count), 32'(sat(TO_EN ? TO : 20)));

        // 4: mismatch on the stop cycle counts, later samples do not
        drive(1, 0, 0, 0, 0); step("t4_start");
        drive(0, 0, 1, 2, 2); step("t4_run");
        drive(0, 1, 1, 4'h3, 4'h1); step("t4_stop");
        check("t4_done", 32'(done), 32'd1);
        check("t4_errors", 32'(error_count), 32'd1);
        check("t4_fe_bits", 32'(first_err_bits), 32'd2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 4'hF, 4'h0); step("t4_ignored");
        end
        check("t4_frozen", 32'(sample_count), 32'd2);

        // 5: reset mid-run after four errors, then a clean run
        drive(1, 0, 0, 0, 0); step("t5_start");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 4'h8, 4'h0); step("t5_run");
        end
        do_reset("t5_reset");
        check("t5_errors0", 32'(error_count), 32'd0);
        drive(1, 0, 0, 0, 0); step("t5_start2");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 4'h6, 4'h6); step("t5_run2");
        end
        drive(0, 1, 0, 0, 0); step("t5_stop2");
        check("t5_pass", 32'(pass), 32'd1);

        // 6: no stop for twelve cycles, then restart
        drive(1, 0, 0, 0, 0); step("t6_start");
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 1, 1); step("t6_run");
        end
        check("t6_timeout", 32'(timeout), 32'(TO_EN));
        check("t6_done", 32'(done), 32'(TO_EN));
        drive(1, 0, 0, 0, 0); step("t6_restart");
        check("t6_cleared", 32'(timeout), 32'd0);
        drive(0, 1, 0, 0, 0); step("t6_stop");

        // random traffic with occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            logic [DW-1:0] r;
            r = DW'($urandom);
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 13) == 0,
                  $urandom_range(0, 3) != 0, r,
                  ($urandom_range(0, 3) == 0) ? DW'($urandom) : r);
            if (i % 173 == 172) do_reset("rnd_reset");
            else step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
